dlatch_wr_ctrl: RTL

- Write controller sitting directly upstream of a 1-bit-per-lane transparent D latch with active-low async clear; drives the latch's d, en and rstn pins.
- Accepts words over a valid/ready handshake and presents each word on lat_d.
- Sequences setup, enable-open and hold windows so lat_d is stable whenever lat_en transitions.
- Also services clear requests by pulsing lat_rstn low, so the downstream latch never sees d change while en is high.

---
 rtl/dlatch_wr_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dlatch_wr_ctrl.sv
// Write controller for a bank of transparent D latches with active-low async clear.
// Sequences setup / enable-open / hold windows so lat_d is stable around every lat_en edge.
module dlatch_wr_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_req,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  output logic             lat_rstn,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(16);

  generate
    if (WIDTH < 1 ||
        SETUP_CYC < 1 || SETUP_CYC > 15 ||
        OPEN_CYC  < 1 || OPEN_CYC  > 15 ||
        HOLD_CYC  < 1 || HOLD_CYC  > 15) begin : g_bad_param
      $fatal(1, "dlatch_wr_ctrl: WIDTH must be >=1 and SETUP/OPEN/HOLD_CYC must be in 1..15");
    end
  endgenerate

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    CLEAR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          clr_pend;

  assign in_ready = (state == IDLE) && !rst && !clear_req && !clr_pend;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_d    <= '0;
      lat_en   <= 1'b0;
      lat_rstn <= 1'b0;
      done     <= 1'b0;
      clr_pend <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          lat_rstn <= 1'b1;
          // A pending or live clear always wins over a waiting word.
          if (clear_req || clr_pend) begin
            state    <= CLEAR;
            lat_rstn <= 1'b0;
            lat_d    <= '0;
            clr_pend <= 1'b0;
          end else if (in_valid && in_ready) begin
            lat_d <= in_data;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end

        SETUP: begin
          if (clear_req) clr_pend <= 1'b1;
          if (cnt == '0) begin
            lat_en <= 1'b1;
            cnt    <= OPEN_LD;
            state  <= OPEN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        OPEN: begin
          if (clear_req) clr_pend <= 1'b1;
          if (cnt == '0) begin
            lat_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        HOLD: begin
          if (clear_req) clr_pend <= 1'b1;
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        CLEAR: begin
          lat_rstn <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state  <= IDLE;
          lat_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
